// File: rtl/action_sched_if.sv
// Request/response bundle between the motion requesters and the action
// scheduler; the master side drives requests, the slave side drives the motor action.
interface action_sched_if;
  logic [1:0] car_mode;
  logic [3:0] ir_action;
  logic [3:0] trk_action;
  logic       trk_valid;
  logic [3:0] obs_action;
  logic       obs_valid;
  logic       obs_block;
  logic [3:0] act_out;
  logic       act_upd;
  logic [1:0] src_sel;
  logic       braking;

  modport master (
    output car_mode, ir_action, trk_action, trk_valid,
    output obs_action, obs_valid, obs_block,
    input  act_out, act_upd, src_sel, braking
  );

  modport slave (
    input  car_mode, ir_action, trk_action, trk_valid,
    input  obs_action, obs_valid, obs_block,
    output act_out, act_upd, src_sel, braking
  );
endinterface

// File: rtl/action_sched.sv
// Motion action scheduler: picks a requester by car mode, enforces a minimum
// hold between motion changes, and inserts a Stop dead-time on direction reversals.
module action_sched #(
  parameter int CNT_W        = 24,
  parameter int MIN_HOLD_CYC = 2500000,
  parameter int DEAD_CYC     = 50000
) (
  input  logic          clk_in,
  input  logic          rst,
  action_sched_if.slave bus
);

  localparam logic [3:0]       ACT_STOP  = 4'hF;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(MIN_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    DEAD = 1'b1
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] hold_cnt_reg;
  logic [CNT_W-1:0] dead_cnt_reg;
  logic [3:0]       pending_reg;
  logic [3:0]       act_reg;
  logic             upd_reg;
  logic [1:0]       src_reg;
  logic             braking_reg;
  logic [3:0]       request;

  function automatic logic is_fwd(input logic [3:0] code);
    return (code >= 4'h1) && (code <= 4'h7);
  endfunction

  function automatic logic is_rev(input logic [3:0] code);
    return (code >= 4'h8) && (code <= 4'hA);
  endfunction

  function automatic logic is_motion(input logic [3:0] code);
    return is_fwd(code) || is_rev(code);
  endfunction

  always_comb begin
    request = ACT_STOP;
    case (bus.car_mode)
      2'b00:   request = bus.ir_action;
      2'b01:   request = bus.trk_valid ? bus.trk_action : ACT_STOP;
      2'b10:   request = bus.obs_valid ? bus.obs_action : ACT_STOP;
      default: request = ACT_STOP;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_reg    <= RUN;
      hold_cnt_reg <= '0;
      dead_cnt_reg <= '0;
      pending_reg  <= ACT_STOP;
      act_reg      <= ACT_STOP;
      upd_reg      <= 1'b0;
      src_reg      <= 2'b00;
      braking_reg  <= 1'b0;
    end else begin
      src_reg <= bus.car_mode;
      upd_reg <= 1'b0;

      if (bus.obs_block) begin
        // Emergency stop also clears any hold so motion can resume at once.
        act_reg      <= ACT_STOP;
        upd_reg      <= (act_reg != ACT_STOP);
        state_reg    <= RUN;
        hold_cnt_reg <= '0;
        dead_cnt_reg <= '0;
        pending_reg  <= ACT_STOP;
        braking_reg  <= 1'b0;
      end else if ((request == ACT_STOP) &&
                   ((act_reg != ACT_STOP) || (state_reg == DEAD))) begin
        // A Stop request bypasses hold and aborts any dead-time in progress.
        act_reg      <= ACT_STOP;
        upd_reg      <= (act_reg != ACT_STOP);
        state_reg    <= RUN;
        dead_cnt_reg <= '0;
        pending_reg  <= ACT_STOP;
        braking_reg  <= 1'b0;
        if (hold_cnt_reg != '0) begin
          hold_cnt_reg <= hold_cnt_reg - CNT_ONE;
        end
      end else begin
        case (state_reg)
          RUN: begin
            if (hold_cnt_reg != '0) begin
              hold_cnt_reg <= hold_cnt_reg - CNT_ONE;
            end
            if ((request != act_reg) && is_motion(request) && (hold_cnt_reg == '0)) begin
              if ((is_fwd(act_reg) && is_rev(request)) ||
                  (is_rev(act_reg) && is_fwd(request))) begin
                act_reg      <= ACT_STOP;
                upd_reg      <= 1'b1;
                pending_reg  <= request;
                dead_cnt_reg <= DEAD_LOAD;
                braking_reg  <= 1'b1;
                state_reg    <= DEAD;
              end else begin
                act_reg      <= request;
                upd_reg      <= 1'b1;
                hold_cnt_reg <= HOLD_LOAD;
              end
            end
          end
          DEAD: begin
            // New motion requests are ignored until the reversal completes.
            if (dead_cnt_reg == '0) begin
              act_reg      <= pending_reg;
              upd_reg      <= 1'b1;
              hold_cnt_reg <= HOLD_LOAD;
              braking_reg  <= 1'b0;
              state_reg    <= RUN;
            end else begin
              dead_cnt_reg <= dead_cnt_reg - CNT_ONE;
            end
          end
          default: state_reg <= RUN;
        endcase
      end
    end
  end

  assign bus.act_out = act_reg;
  assign bus.act_upd = upd_reg;
  assign bus.src_sel = src_reg;
  assign bus.braking = braking_reg;

endmodule

// File: tb/tb_action_sched.sv
// Bench for action_sched: timestamp-based behavioural model checked every cycle,
// plus directed literal expectations along the scenario.
module tb_action_sched;
  localparam int M = 8;
  localparam int D = 4;
  localparam logic [3:0] ST = 4'hF;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;

  action_sched_if sif ();

  action_sched #(
    .CNT_W(24),
    .MIN_HOLD_CYC(M),
    .DEAD_CYC(D)
  ) dut (
    .clk_in(clk_in),
    .rst(rst),
    .bus(sif)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [3:0] actual, input logic [3:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic fwd(input logic [3:0] c);
    return (c >= 4'h1) && (c <= 4'h7);
  endfunction

  function automatic logic rev(input logic [3:0] c);
    return (c >= 4'h8) && (c <= 4'hA);
  endfunction

  // Model: hold and dead-time tracked as absolute edge numbers, not counters.
  logic [3:0] m_act = ST;
  logic [3:0] m_pending = ST;
  logic       m_upd = 1'b0;
  logic       m_dead = 1'b0;
  logic [1:0] m_src = 2'b00;
  int         cyc = 0;
  int         hold_ok_at = 0;
  int         dead_end = 0;

  always @(posedge clk_in or posedge rst) begin : model
    logic [3:0] req;
    logic [3:0] prev;
    if (rst) begin
      m_act = ST; m_pending = ST; m_upd = 1'b0; m_dead = 1'b0; m_src = 2'b00;
      hold_ok_at = cyc;
    end else begin
      cyc++;
      case (sif.car_mode)
        2'b00:   req = sif.ir_action;
        2'b01:   req = sif.trk_valid ? sif.trk_action : ST;
        2'b10:   req = sif.obs_valid ? sif.obs_action : ST;
        default: req = ST;
      endcase
      prev  = m_act;
      m_src = sif.car_mode;
      if (sif.obs_block) begin
        m_act = ST; m_dead = 1'b0; m_pending = ST; hold_ok_at = cyc;
      end else if (req == ST && (m_act != ST || m_dead)) begin
        m_act = ST; m_dead = 1'b0; m_pending = ST;
      end else if (m_dead) begin
        if (cyc == dead_end) begin
          m_act = m_pending; m_dead = 1'b0; hold_ok_at = cyc + M;
        end
      end else if (req != m_act && (fwd(req) || rev(req)) && cyc >= hold_ok_at) begin
        if ((fwd(m_act) && rev(req)) || (rev(m_act) && fwd(req))) begin
          m_act = ST; m_pending = req; m_dead = 1'b1; dead_end = cyc + D;
        end else begin
          m_act = req; hold_ok_at = cyc + M;
        end
      end
      m_upd = (m_act != prev);
    end
  end

  always @(negedge clk_in) begin
    if (!rst) begin
      check("model_act_out", sif.act_out, m_act);
      check("model_act_upd", 4'(sif.act_upd), 4'(m_upd));
      check("model_src_sel", 4'(sif.src_sel), 4'(m_src));
      check("model_braking", 4'(sif.braking), 4'(m_dead));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #2;
  endtask

  initial begin
    sif.car_mode = 2'b00; sif.ir_action = ST;
    sif.trk_action = 4'h0; sif.trk_valid = 1'b0;
    sif.obs_action = 4'h0; sif.obs_valid = 1'b0; sif.obs_block = 1'b0;
    tick(3);
    rst = 1'b0;
    check("reset_act", sif.act_out, ST);
    check("reset_upd", 4'(sif.act_upd), 4'h0);
    check("reset_src", 4'(sif.src_sel), 4'h0);
    check("reset_brk", 4'(sif.braking), 4'h0);
    tick(1);

    // Hold: 3 then 4 exactly M edges later
    sif.ir_action = 4'h3;
    tick(1);
    check("hold_first_act", sif.act_out, 4'h3);
    check("hold_first_upd", 4'(sif.act_upd), 4'h1);
    tick(1);
    check("hold_upd_one_cycle", 4'(sif.act_upd), 4'h0);
    sif.ir_action = 4'h4;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check("hold_blocked", sif.act_out, 4'h3);
    end
    tick(1);
    check("hold_expired_act", sif.act_out, 4'h4);
    check("hold_expired_upd", 4'(sif.act_upd), 4'h1);

    // Reversal 4 -> A with dead-time
    sif.ir_action = 4'hA;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      check("rev_hold_act", sif.act_out, 4'h4);
    end
    tick(1);
    check("rev_stop_act", sif.act_out, ST);
    check("rev_stop_upd", 4'(sif.act_upd), 4'h1);
    check("rev_stop_brk", 4'(sif.braking), 4'h1);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("rev_dead_brk", 4'(sif.braking), 4'h1);
      check("rev_dead_act", sif.act_out, ST);
    end
    tick(1);
    check("rev_apply_act", sif.act_out, 4'hA);
    check("rev_apply_upd", 4'(sif.act_upd), 4'h1);
    check("rev_apply_brk", 4'(sif.braking), 4'h0);

    // Stop bypasses hold; non-motion code ignored
    sif.ir_action = ST;
    tick(1);
    check("bypass_act", sif.act_out, ST);
    sif.ir_action = 4'hB;
    tick(1);
    check("ignored_act", sif.act_out, ST);
    check("ignored_upd", 4'(sif.act_upd), 4'h0);
    sif.ir_action = 4'h4;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("leave_stop_hold", sif.act_out, ST);
    end
    tick(1);
    check("leave_stop_act", sif.act_out, 4'h4);

    // Emergency during hold clears hold
    tick(1);
    sif.obs_block = 1'b1;
    tick(1);
    check("emerg_act", sif.act_out, ST);
    check("emerg_upd", 4'(sif.act_upd), 4'h1);
    tick(1);
    check("emerg_held", sif.act_out, ST);
    sif.obs_block = 1'b0;
    tick(1);
    check("emerg_resume", sif.act_out, 4'h4);

    // Source select
    sif.car_mode = 2'b01;
    tick(1);
    check("trk_invalid_act", sif.act_out, ST);
    check("trk_src", 4'(sif.src_sel), 4'h1);
    tick(8);
    sif.trk_valid = 1'b1; sif.trk_action = 4'h5;
    tick(1);
    check("trk_valid_act", sif.act_out, 4'h5);
    sif.car_mode = 2'b11;
    tick(1);
    check("forced_stop_act", sif.act_out, ST);
    check("forced_stop_src", 4'(sif.src_sel), 4'h3);
    sif.car_mode = 2'b10; sif.obs_valid = 1'b1; sif.obs_action = 4'h2;
    tick(6);
    check("obs_src_hold", sif.act_out, ST);
    tick(1);
    check("obs_src_act", sif.act_out, 4'h2);
    sif.obs_action = 4'hC;
    tick(1);
    check("obs_nonmotion", sif.act_out, 4'h2);

    // Stop request aborts dead-time
    sif.car_mode = 2'b00; sif.ir_action = 4'h9;
    tick(6);
    check("abort_pre", sif.act_out, 4'h2);
    tick(1);
    check("abort_dead_brk", 4'(sif.braking), 4'h1);
    tick(1);
    sif.ir_action = ST;
    tick(1);
    check("abort_brk", 4'(sif.braking), 4'h0);
    check("abort_upd", 4'(sif.act_upd), 4'h0);
    sif.ir_action = 4'h9;
    tick(1);
    check("abort_leave_stop", sif.act_out, 4'h9);

    // Async reset mid-dead-time
    sif.ir_action = 4'h3;
    tick(7);
    check("rst_pre_dead_brk", 4'(sif.braking), 4'h0);
    tick(1);
    check("rst_dead_brk", 4'(sif.braking), 4'h1);
    #1 rst = 1'b1;
    #1;
    check("rst_async_act", sif.act_out, ST);
    check("rst_async_brk", 4'(sif.braking), 4'h0);
    tick(2);
    rst = 1'b0;
    tick(1);
    check("rst_run_act", sif.act_out, 4'h3);
    check("rst_run_brk", 4'(sif.braking), 4'h0);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/action_sched.md
Name: action_sched

Overview:
- Sits between the IR command decoder, the line-tracker and the obstacle-avoid units on one side and the motor PWM driver on the other.
- Selects one requester by car mode and forwards its 4-bit action code.
- Enforces a minimum hold time between motion changes.
- Inserts a stop dead-time on every forward/reverse reversal.
- An obstacle emergency forces an immediate Stop.

Parameters:
- CNT_W, 24, width of the hold and dead-time counters.
- MIN_HOLD_CYC, 2500000, minimum cycles a motion action is held before another non-Stop action is applied (must be ≥1 and < 2^CNT_W).
- DEAD_CYC, 50000, cycles of forced Stop inserted on a direction reversal (must be ≥1 and < 2^CNT_W).

Ports:
- clk_in  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- car_mode  in  2  source select: 00 IR, 01 tracker, 10 obstacle-avoid, 11 forced Stop.
- ir_action  in  4  action code from the IR decoder (always valid).
- trk_action  in  4  tracker action code.
- trk_valid  in  1  trk_action is valid.
- obs_action  in  4  obstacle-avoid action code.
- obs_valid  in  1  obs_action is valid.
- obs_block  in  1  emergency obstacle; Stop overrides everything.
- act_out  out  4  action code to the motor driver.
- act_upd  out  1  one-cycle pulse when act_out changes value.
- src_sel  out  2  registered copy of the active source (car_mode).
- braking  out  1  high while in dead-time.

Behaviour:
- Action codes:
  - Forward class: 1–7. Reverse class: 8, 9, A. Stop: F.
  - Codes 0 and B–E are non-motion; a request carrying one is ignored (act_out unchanged, no pulse).
- Reset (async, rst=1):
  - act_out=F, act_upd=0, src_sel=00, braking=0.
  - State RUN, hold_cnt=0, dead_cnt=0, pending=F.
  - Reset mid-dead-time aborts the dead-time and drops pending.
- Request (combinational):
  - Mode 00 → ir_action.
  - Mode 01 → trk_action if trk_valid, else F.
  - Mode 10 → obs_action if obs_valid, else F.
  - Mode 11 → F.
- src_sel follows car_mode with 1-cycle latency.
- Priority at each edge, highest first:
  - 1) obs_block=1: act_out←F, state←RUN, hold_cnt←0, braking←0, pending dropped. Re-evaluated every cycle; act_out stays F while asserted.
  - 2) Request=F and act_out≠F: act_out←F at the next edge, bypassing hold. In DEAD, pending is dropped, braking←0, state←RUN.
  - 3) FSM rules below.
- State RUN:
  - hold_cnt decrements to 0 and saturates there.
  - If request ≠ act_out, request is a motion code, and hold_cnt=0:
    - Reversal case: act_out and request are in opposite classes (forward vs reverse). act_out←F, pending←request, dead_cnt←DEAD_CYC−1, braking←1, state←DEAD.
    - Otherwise: act_out←request, hold_cnt←MIN_HOLD_CYC−1.
  - Leaving Stop (act_out=F) never triggers dead-time.
- State DEAD:
  - dead_cnt decrements each cycle. Request changes during DEAD are not sampled, except Stop (rule 2).
  - When dead_cnt=0: act_out←pending, hold_cnt←MIN_HOLD_CYC−1, braking←0, state←RUN.
- Timing:
  - If the dead-time Stop is applied at edge n, pending appears at edge n+DEAD_CYC; braking is high for exactly DEAD_CYC cycles.
  - If a motion action is applied at edge n, the earliest next non-Stop change is at edge n+MIN_HOLD_CYC.
  - Request-to-act_out latency is 1 cycle when not blocked by hold.
- act_upd:
  - Registered; high in the cycle after any edge where act_out changed value.
  - Covers entry to dead-time Stop, obs_block Stop and the pending apply.
  - Never asserted twice for the same value.
- Simultaneous events:
  - obs_block together with hold/dead expiry: obs_block wins.
  - Mode change during hold: the new source's request waits for hold expiry unless it is F.

Test Plan (MIN_HOLD_CYC=8, DEAD_CYC=4):
- Reset: rst=1 mid-DEAD → act_out=F and braking=0 immediately, without a clock edge; after release, state RUN.
- Hold: mode 00, ir_action 3 → act_out=3 one edge later, act_upd pulse of 1 cycle. Then ir_action 4 two cycles later → act_out=4 exactly 8 edges after the 3 was applied.
- Reversal: act_out=3, hold expired, ir_action A → act_out=F with act_upd, braking high for 4 cycles, then act_out=A with a second act_upd pulse.
- Emergency: act_out=4 during hold, obs_block=1 → act_out=F next edge. After obs_block=0 with ir_action 4 → act_out=4 next edge (hold was cleared).
- Source select: mode 01, trk_valid=0 → act_out=F. trk_valid=1, trk_action 5 → act_out=5 next edge, src_sel=01. mode 11 → F next edge.
- Stop bypass and ignored codes: act_out=3 in hold, ir_action F → act_out=F next edge. ir_action B → no change, no act_upd.
